// File: rtl/obsidian_decode_hazard_stage.sv
// Decode stage: register file with write-through bypass, opcode decode, immediate
// extension, load-use hazard detection and the ID/EX pipeline register.
module obsidian_decode_hazard_stage #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [PC_W-1:0]   if_pc,
    input  logic [31:0]       if_instr,
    input  logic              flush,
    input  logic              wb_regwrite,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              id_stall,
    output logic              ex_valid,
    output logic              ex_regwrite,
    output logic              ex_memtoreg,
    output logic              ex_branch,
    output logic              ex_ubranch,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_alusrc,
    output logic [1:0]        ex_aluop,
    output logic              ex_illegal,
    output logic [PC_W-1:0]   ex_pc,
    output logic [DATA_W-1:0] ex_rn_data,
    output logic [DATA_W-1:0] ex_rm_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [10:0]       ex_opcode,
    output logic [5:0]        ex_shamt,
    output logic [4:0]        ex_rd
);

    localparam logic [AW-1:0] ZREG = AW'(NREG - 1);

    logic [DATA_W-1:0] regs [NREG];
    logic [10:0]       opcode;
    logic              is_r, is_i, is_ld, is_st, is_cb, is_b;
    logic [8:0]        ctrl;
    logic              illegal;
    logic [DATA_W-1:0] imm;
    logic [AW-1:0]     rn_addr, rm_addr;
    logic [DATA_W-1:0] rn_data, rm_data;
    logic              reads_rm;
    logic              take;

    assign opcode = if_instr[31:21];

    // Instruction class and control vector {regwrite,memtoreg,branch,ubranch,memread,memwrite,aluop,alusrc}
    always_comb begin
        is_r    = 1'b0;
        is_i    = 1'b0;
        is_ld   = 1'b0;
        is_st   = 1'b0;
        is_cb   = 1'b0;
        is_b    = 1'b0;
        ctrl    = '0;
        illegal = 1'b0;
        casez (opcode)
            11'h458, 11'h658, 11'h450, 11'h550,
            11'h650, 11'h69A, 11'h69B: begin is_r  = 1'b1; ctrl = 9'b1_0_0_0_0_0_10_0; end
            11'b1001000100?,
            11'b1101000100?:           begin is_i  = 1'b1; ctrl = 9'b1_0_0_0_0_0_10_1; end
            11'h7C2:                   begin is_ld = 1'b1; ctrl = 9'b1_1_0_0_1_0_00_1; end
            11'h7C0:                   begin is_st = 1'b1; ctrl = 9'b0_0_0_0_0_1_00_1; end
            11'b1011010????:           begin is_cb = 1'b1; ctrl = 9'b0_0_1_0_0_0_01_0; end
            11'b000101?????:           begin is_b  = 1'b1; ctrl = 9'b0_0_0_1_0_0_01_0; end
            default:                   illegal = 1'b1;
        endcase
    end

    always_comb begin
        imm = '0;
        if (is_ld || is_st)
            imm = {{(DATA_W-9){if_instr[20]}}, if_instr[20:12]};
        else if (is_i)
            imm = {{(DATA_W-12){1'b0}}, if_instr[21:10]};
        else if (is_cb)
            imm = {{(DATA_W-19){if_instr[23]}}, if_instr[23:5]};
        else if (is_b)
            imm = {{(DATA_W-26){if_instr[25]}}, if_instr[25:0]};
    end

    // Stores and compare-branches name their second source in the Rt field
    assign rn_addr  = if_instr[5 +: AW];
    assign rm_addr  = (is_st || is_cb) ? if_instr[0 +: AW] : if_instr[16 +: AW];
    assign reads_rm = is_r || is_st || is_cb;

    always_comb begin
        rn_data = regs[rn_addr];
        rm_data = regs[rm_addr];
        if (rn_addr == ZREG)
            rn_data = '0;
        else if (wb_regwrite && wb_addr == rn_addr)
            rn_data = wb_data;
        if (rm_addr == ZREG)
            rm_data = '0;
        else if (wb_regwrite && wb_addr == rm_addr)
            rm_data = wb_data;
    end

    always_comb begin
        id_stall = 1'b0;
        if (!flush && ex_valid && ex_memread && if_valid && ex_rd[AW-1:0] != ZREG &&
            (ex_rd[AW-1:0] == rn_addr || (reads_rm && ex_rd[AW-1:0] == rm_addr)))
            id_stall = 1'b1;
    end

    assign take = if_valid && !id_stall && !flush;

    // The zero register is never written, so its storage always stays cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (wb_regwrite && wb_addr != ZREG) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Bubbles clear only valid and control bits; the data fields follow the fetch slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_branch   <= 1'b0;
            ex_ubranch  <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_aluop    <= 2'b00;
            ex_alusrc   <= 1'b0;
            ex_illegal  <= 1'b0;
            ex_pc       <= '0;
            ex_rn_data  <= '0;
            ex_rm_data  <= '0;
            ex_imm      <= '0;
            ex_opcode   <= '0;
            ex_shamt    <= '0;
            ex_rd       <= '0;
        end else begin
            ex_valid <= take;
            {ex_regwrite, ex_memtoreg, ex_branch, ex_ubranch,
             ex_memread, ex_memwrite, ex_aluop, ex_alusrc} <= take ? ctrl : 9'b0;
            ex_illegal <= take && illegal;
            ex_pc      <= if_pc;
            ex_rn_data <= rn_data;
            ex_rm_data <= rm_data;
            ex_imm     <= imm;
            ex_opcode  <= opcode;
            ex_shamt   <= if_instr[15:10];
            ex_rd      <= if_instr[4:0];
        end
    end

endmodule

// File: tb/tb_obsidian_decode_hazard_stage.sv
// Bench for the decode/hazard stage: a spec-level model checked every cycle, plus
// directed vectors with hand-computed literal expectations.
module tb_obsidian_decode_hazard_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;
    logic        wb_regwrite;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        id_stall, ex_valid, ex_regwrite, ex_memtoreg, ex_branch, ex_ubranch;
    logic        ex_memread, ex_memwrite, ex_alusrc, ex_illegal;
    logic [1:0]  ex_aluop;
    logic [31:0] ex_pc, ex_rn_data, ex_rm_data, ex_imm;
    logic [10:0] ex_opcode;
    logic [5:0]  ex_shamt;
    logic [4:0]  ex_rd;

    int checks   = 0;
    int failures = 0;
    logic sampledStall;

    obsidian_decode_hazard_stage dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .flush(flush), .wb_regwrite(wb_regwrite), .wb_addr(wb_addr), .wb_data(wb_data),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
        .ex_memtoreg(ex_memtoreg), .ex_branch(ex_branch), .ex_ubranch(ex_ubranch),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc),
        .ex_aluop(ex_aluop), .ex_illegal(ex_illegal), .ex_pc(ex_pc),
        .ex_rn_data(ex_rn_data), .ex_rm_data(ex_rm_data), .ex_imm(ex_imm),
        .ex_opcode(ex_opcode), .ex_shamt(ex_shamt), .ex_rd(ex_rd)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic        ill;
        logic [8:0]  ctrl;
        logic [31:0] pc, rn, rm, imm;
        logic [10:0] opc;
        logic [5:0]  shamt;
        logic [4:0]  rd;
    } ex_t;

    ex_t         mEx;
    logic [31:0] mRegs [32];

    function automatic logic isRtype(input logic [10:0] op);
        return op inside {11'h458, 11'h658, 11'h450, 11'h550, 11'h650, 11'h69A, 11'h69B};
    endfunction
    function automatic logic isItype(input logic [10:0] op);
        return op inside {11'h488, 11'h489, 11'h688, 11'h689};
    endfunction
    function automatic logic isCb(input logic [10:0] op);
        return op[10:4] == 7'b1011010;
    endfunction
    function automatic logic isB(input logic [10:0] op);
        return op[10:5] == 6'b000101;
    endfunction

    // {illegal, regwrite, memtoreg, branch, ubranch, memread, memwrite, aluop, alusrc}
    function automatic logic [9:0] mDecode(input logic [10:0] op);
        if (isRtype(op))      return 10'b0_100000_10_0;
        if (isItype(op))      return 10'b0_100000_10_1;
        if (op == 11'h7C2)    return 10'b0_110010_00_1;
        if (op == 11'h7C0)    return 10'b0_000001_00_1;
        if (isCb(op))         return 10'b0_001000_01_0;
        if (isB(op))          return 10'b0_000100_01_0;
        return 10'b1_000000_00_0;
    endfunction

    function automatic logic [31:0] mImm(input logic [31:0] ins);
        logic [10:0] op = ins[31:21];
        if (op == 11'h7C2 || op == 11'h7C0) return {{23{ins[20]}}, ins[20:12]};
        if (isItype(op))                    return {20'b0, ins[21:10]};
        if (isCb(op))                       return {{13{ins[23]}}, ins[23:5]};
        if (isB(op))                        return {{6{ins[25]}}, ins[25:0]};
        return 32'h0;
    endfunction

    function automatic logic [4:0] mRm(input logic [31:0] ins);
        if (ins[31:21] == 11'h7C0 || isCb(ins[31:21])) return ins[4:0];
        return ins[20:16];
    endfunction

    function automatic logic mReadsRm(input logic [31:0] ins);
        return isRtype(ins[31:21]) || ins[31:21] == 11'h7C0 || isCb(ins[31:21]);
    endfunction

    function automatic logic [31:0] mRead(input logic [4:0] a);
        if (a == 5'd31) return 32'h0;
        if (wb_regwrite && wb_addr == a) return wb_data;
        return mRegs[a];
    endfunction

    function automatic logic mStall();
        if (flush || !if_valid || !mEx.valid || mEx.ctrl[4] == 1'b0 || mEx.rd == 5'd31)
            return 1'b0;
        return (mEx.rd == if_instr[9:5]) || (mReadsRm(if_instr) && mEx.rd == mRm(if_instr));
    endfunction

    // Model of the EX slot and register file, advanced on every rising edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mEx = '0;
            for (int i = 0; i < 32; i++) mRegs[i] = 32'h0;
        end else begin
            ex_t         nxt;
            logic [9:0]  dec;
            nxt = '0;
            if (if_valid && !flush && !mStall()) begin
                dec       = mDecode(if_instr[31:21]);
                nxt.valid = 1'b1;
                nxt.ill   = dec[9];
                nxt.ctrl  = dec[8:0];
                nxt.pc    = if_pc;
                nxt.rn    = mRead(if_instr[9:5]);
                nxt.rm    = mRead(mRm(if_instr));
                nxt.imm   = mImm(if_instr);
                nxt.opc   = if_instr[31:21];
                nxt.shamt = if_instr[15:10];
                nxt.rd    = if_instr[4:0];
            end
            if (wb_regwrite && wb_addr != 5'd31) mRegs[wb_addr] = wb_data;
            mEx = nxt;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checkOutput("stall", {63'b0, id_stall}, {63'b0, mStall()});
            checkOutput("ctrl", {53'b0, ex_valid, ex_illegal, ex_regwrite, ex_memtoreg, ex_branch,
                                 ex_ubranch, ex_memread, ex_memwrite, ex_aluop, ex_alusrc},
                        {53'b0, mEx.valid, mEx.ill, mEx.ctrl});
            if (mEx.valid) begin
                checkOutput("pc", {32'b0, ex_pc}, {32'b0, mEx.pc});
                checkOutput("operands", {ex_rn_data, ex_rm_data}, {mEx.rn, mEx.rm});
                checkOutput("imm", {32'b0, ex_imm}, {32'b0, mEx.imm});
                checkOutput("fields", {42'b0, ex_opcode, ex_shamt, ex_rd},
                            {42'b0, mEx.opc, mEx.shamt, mEx.rd});
            end
        end
    end

    // Drives one fetch/writeback slot, then returns just after the capturing edge
    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic fl,
                                 input logic we, input logic [4:0] wa, input logic [31:0] wd);
        if_valid    = v;
        if_instr    = ins;
        flush       = fl;
        wb_regwrite = we;
        wb_addr     = wa;
        wb_data     = wd;
        #1 sampledStall = id_stall;
        @(posedge clk);
        #2;
        if_pc = if_pc + 32'd4;
    endtask

    task automatic wbOnly(input logic [4:0] wa, input logic [31:0] wd);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, wa, wd);
    endtask

    task automatic issue(input logic [31:0] ins);
        applyStimulus(1'b1, ins, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    function automatic logic [63:0] ctrlNow();
        return {54'b0, ex_valid, ex_regwrite, ex_memtoreg, ex_branch, ex_ubranch,
                ex_memread, ex_memwrite, ex_aluop, ex_alusrc};
    endfunction

    localparam logic [31:0] ADD3  = {11'h458, 5'd2, 6'd0, 5'd1, 5'd3};
    localparam logic [31:0] SUB8  = {11'h658, 5'd31, 6'd0, 5'd4, 5'd8};
    localparam logic [31:0] LDUR5 = {11'h7C2, 9'h1F8, 2'b00, 5'd1, 5'd5};
    localparam logic [31:0] ADD6  = {11'h458, 5'd2, 6'd0, 5'd5, 5'd6};
    localparam logic [31:0] CBZ7  = {8'hB4, 19'h7FFFF, 5'd7};
    localparam logic [31:0] ADDI9 = {10'b1001000100, 12'hABC, 5'd1, 5'd9};
    localparam logic [31:0] ADDI5 = {10'b1001000100, 12'h140, 5'd1, 5'd9};
    localparam logic [31:0] STUR2 = {11'h7C0, 9'd4, 2'b00, 5'd1, 5'd2};
    localparam logic [31:0] BM2   = {6'b000101, 26'h3FFFFFE};
    localparam logic [31:0] LSL10 = {11'h69B, 5'd0, 6'd3, 5'd1, 5'd10};
    localparam logic [31:0] LDUR9 = {11'h7C2, 9'd0, 2'b00, 5'd1, 5'd9};
    localparam logic [31:0] STUR9 = {11'h7C0, 9'd0, 2'b00, 5'd2, 5'd9};
    localparam logic [31:0] LDZR  = {11'h7C2, 9'd0, 2'b00, 5'd1, 5'd31};
    localparam logic [31:0] ADDZR = {11'h458, 5'd31, 6'd0, 5'd31, 5'd3};

    initial begin
        rst_n = 1'b0; if_valid = 1'b0; if_pc = 32'h1000; if_instr = 32'h0;
        flush = 1'b0; wb_regwrite = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
        #2;
        checkOutput("reset_valid", {63'b0, ex_valid}, 64'd0);
        checkOutput("reset_stall", {63'b0, id_stall}, 64'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); #2;

        wbOnly(5'd1, 32'd5);
        wbOnly(5'd2, 32'd7);
        wbOnly(5'd31, 32'h1234);
        wbOnly(5'd7, 32'h77);

        issue(ADD3);
        checkOutput("add_ops", {ex_rn_data, ex_rm_data}, {32'd5, 32'd7});
        checkOutput("add_ctrl", ctrlNow(), {54'b0, 10'b1_100000_10_0});
        checkOutput("add_rd", {59'b0, ex_rd}, 64'd3);

        applyStimulus(1'b1, SUB8, 1'b0, 1'b1, 5'd4, 32'hDEAD);
        checkOutput("sub_bypass_zr", {ex_rn_data, ex_rm_data}, {32'hDEAD, 32'h0});

        issue(LDUR5);
        checkOutput("ldur_imm", {32'b0, ex_imm}, 64'hFFFFFFF8);
        checkOutput("ldur_ctrl", ctrlNow(), {54'b0, 10'b1_110010_00_1});
        issue(ADD6);
        checkOutput("loaduse_stall", {63'b0, sampledStall}, 64'd1);
        checkOutput("loaduse_bubble", ctrlNow(), 64'd0);
        applyStimulus(1'b1, ADD6, 1'b0, 1'b1, 5'd5, 32'h55);
        checkOutput("after_stall", {63'b0, sampledStall}, 64'd0);
        checkOutput("after_stall_ops", {ex_rn_data, ex_rm_data}, {32'h55, 32'd7});

        issue(LDUR5);
        applyStimulus(1'b1, ADD6, 1'b1, 1'b0, 5'd0, 32'h0);
        checkOutput("flush_nostall", {63'b0, sampledStall}, 64'd0);
        checkOutput("flush_bubble", {63'b0, ex_valid}, 64'd0);
        issue(ADD6);
        checkOutput("post_flush", {62'b0, sampledStall, ex_valid}, 64'd1);

        issue(CBZ7);
        checkOutput("cbz_ctrl", ctrlNow(), {54'b0, 10'b1_001000_01_0});
        checkOutput("cbz_rm", {32'b0, ex_rm_data}, 64'h77);
        checkOutput("cbz_imm", {32'b0, ex_imm}, 64'hFFFFFFFF);
        issue(32'h0);
        checkOutput("illegal", {ctrlNow()[62:0], ex_illegal}, {53'b0, 10'b1_000000_00_0, 1'b1});

        issue(ADDI9);
        checkOutput("addi_imm", {32'b0, ex_imm}, 64'hABC);
        issue(STUR2);
        checkOutput("stur_rm", {32'b0, ex_rm_data}, 64'd7);
        issue(BM2);
        checkOutput("b_imm", {32'b0, ex_imm}, 64'hFFFFFFFE);
        issue(LSL10);
        checkOutput("lsl_shamt", {58'b0, ex_shamt}, 64'd3);
        applyStimulus(1'b0, ADD3, 1'b0, 1'b0, 5'd0, 32'h0);
        checkOutput("invalid_bubble", {63'b0, ex_valid}, 64'd0);

        issue(LDUR9);
        issue(STUR9);
        checkOutput("stur_rt_stall", {63'b0, sampledStall}, 64'd1);
        issue(STUR9);
        issue(LDUR5);
        issue(ADDI5);
        checkOutput("addi_no_rm_stall", {63'b0, sampledStall}, 64'd0);
        issue(LDZR);
        issue(ADDZR);
        checkOutput("zr_no_stall", {63'b0, sampledStall}, 64'd0);

        issue(ADD3);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_reset", {ctrlNow()[31:0], ex_rn_data}, 64'd0);
        checkOutput("async_reset_stall", {63'b0, id_stall}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        issue(ADD3);
        checkOutput("regs_cleared", {ex_rn_data, ex_rm_data}, 64'd0);
        issue(32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/obsidian_decode_hazard_stage.md
OBSIDIAN_DECODE_HAZARD_STAGE -- requirements
Module: obsidian_decode_hazard_stage

Interface
- REQ-001 SHALL have parameter DATA_W, default 32, register and operand data width.
- REQ-002 SHALL have parameter PC_W, default 32, program-counter width.
- REQ-003 SHALL have parameter NREG, default 32, register count; index NREG-1 is the zero register; NREG is a power of 2, at most 32.
- REQ-004 SHALL have parameter AW, default $clog2(NREG), register address width.
- REQ-005 SHALL have ports, one per line (name, direction, width, meaning):
  - clk  in  1  clock; all state updates on rising edge.
  - rst_n  in  1  reset, asynchronous, active-low.
  - if_valid  in  1  fetch slot holds a valid instruction.
  - if_pc  in  PC_W  PC of the fetched instruction.
  - if_instr  in  32  fetched instruction.
  - flush  in  1  kill the instruction entering EX.
  - wb_regwrite  in  1  writeback enable.
  - wb_addr  in  AW  writeback register address.
  - wb_data  in  DATA_W  writeback data.
  - id_stall  out  1  combinational; fetch must hold PC and if_instr.
  - ex_valid  out  1  EX slot valid.
  - ex_regwrite, ex_memtoreg, ex_branch, ex_ubranch, ex_memread, ex_memwrite, ex_alusrc  out  1 each  control bits.
  - ex_aluop  out  2  ALU operation class.
  - ex_illegal  out  1  opcode not decoded.
  - ex_pc  out  PC_W  passed PC.
  - ex_rn_data, ex_rm_data  out  DATA_W  operand data.
  - ex_imm  out  DATA_W  extended immediate.
  - ex_opcode  out  11  instr[31:21].
  - ex_shamt  out  6  instr[15:10].
  - ex_rd  out  5  instr[4:0].

Function
- REQ-006 Register file: NREG x DATA_W; reads of index NREG-1 return 0; writes to NREG-1 are ignored.
- REQ-007 Read addresses: rn = instr[9:5]; rm = instr[20:16], except STUR and CBZ/CBNZ (reg2loc), where rm = instr[4:0]. Address bits at and above AW are ignored.
- REQ-008 Write-through bypass: when wb_regwrite=1 and wb_addr equals a read address other than NREG-1, the operand captured that cycle is wb_data.
- REQ-009 Decode table (order: regwrite, memtoreg, branch, ubranch, memread, memwrite, aluop, alusrc):
  - ADD 458, SUB 658, AND 450, ORR 550, EOR 650, LSR 69A, LSL 69B: 1,0,0,0,0,0,10,0.
  - ADDI 488/489, SUBI 688/689: 1,0,0,0,0,0,10,1.
  - LDUR 7C2: 1,1,0,0,1,0,00,1.
  - STUR 7C0: 0,0,0,0,0,1,00,1.
  - CBZ/CBNZ (instr[31:25]=1011010): 0,0,1,0,0,0,01,0.
  - B (instr[31:26]=000101): 0,0,0,1,0,0,01,0.
  - Any other opcode: all zero, ex_illegal=1.
- REQ-010 Immediate extension:
  - D-type: sign-extend instr[20:12].
  - I-type: zero-extend instr[21:10].
  - CB: sign-extend instr[23:5].
  - B: sign-extend instr[25:0].
  - Otherwise ex_imm = 0.
- REQ-011 Latency: one cycle; fields from a slot with if_valid=1 and no stall/flush appear on ex_* at the next rising edge.
- REQ-012 Load-use hazard: id_stall=1 when ex_valid=1, ex_memread=1, ex_rd != NREG-1, if_valid=1, and ex_rd equals rn, or equals rm of an instruction that reads rm.
- REQ-013 While id_stall=1, a bubble is inserted at the next edge: ex_valid and all control bits = 0, data fields don't-care. The stall lasts exactly one cycle per hazard.
- REQ-014 flush=1 forces a bubble next edge regardless of stall; id_stall is forced 0 while flush=1.
- REQ-015 if_valid=0 produces a bubble.
- REQ-016 Register-file write occurs on every edge with wb_regwrite=1, including stall and flush cycles.

Reset
- REQ-017 rst_n=0 asynchronously clears all ex_* outputs and all register-file entries to 0; id_stall reads 0 during reset.
- REQ-018 First capture happens on the first rising edge after rst_n rises.

Verification
- REQ-019 Write 5 to X1 and 7 to X2 via wb, then ADD X3,X1,X2 -> next cycle ex_rn_data=5, ex_rm_data=7, control 1,0,0,0,0,0,10,0, ex_rd=3.
- REQ-020 Same-cycle wb X4=0xDEAD with SUB reading X4 -> ex_rn_data=0xDEAD; a read of X31 returns 0 even after a wb write to X31.
- REQ-021 LDUR X5,[X1,#-8] then ADD X6,X5,X2 -> LDUR ex_imm=0xFFFFFFF8; id_stall=1 for one cycle, then a bubble, then the ADD with correct operands.
- REQ-022 LDUR X5 followed by flush=1 on the hazard cycle -> id_stall=0, bubble, no extra stall.
- REQ-023 CBZ X7 with offset -1 -> ex_branch=1, aluop 01, rm address 7, ex_imm all ones; opcode 0x000 -> ex_illegal=1, all controls 0.
- REQ-024 Assert rst_n=0 mid-stream with ex_valid=1 -> outputs 0 without a clock edge; registers read 0 afterward.
